lmsm_sequencer: RTL

LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

---
 rtl/lmsm_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lmsm_sequencer.sv
// -----------------------------------------------------------------------------
// lmsm_sequencer
// Sequences multi-register load (LM) and store (SM) transfers. One start pulse
// latches a register mask, a base address and the direction. The block then
// walks the set mask bits in ascending order and performs one memory access per
// set bit at consecutive addresses. Each access stalls for as long as the
// memory holds mem_ready low.
//
// Ports
//   clk         in   1   system clock, rising edge
//   proc_rst    in   1   asynchronous active-high reset
//   start       in   1   begin transfer (honoured in IDLE only)
//   is_store    in   1   1 = SM (reg -> mem), 0 = LM (mem -> reg)
//   reg_list    in   8   register mask, bit k selects R(k)
//   base_addr   in   16  first memory address
//   mem_ready   in   1   memory completes current access this cycle
//   busy        out  1   sequencer not idle
//   done        out  1   one-cycle completion pulse
//   rf_index    out  3   register index of current transfer
//   rf_wen      out  1   register-file write strobe (LM)
//   mem_addr    out  16  current memory address
//   mem_read    out  1   memory read request (LM)
//   mem_write   out  1   memory write request (SM)
//   xfer_count  out  4   completed transfers in current/last operation
// -----------------------------------------------------------------------------
module lmsm_sequencer (
   input  logic        clk,
   input  logic        proc_rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [7:0]  reg_list,
   input  logic [15:0] base_addr,
   input  logic        mem_ready,
   output logic        busy,
   output logic        done,
   output logic [2:0]  rf_index,
   output logic        rf_wen,
   output logic [15:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  xfer_count
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t      state_q,    state_d;
   logic [7:0]  mask_q,     mask_d;
   logic [15:0] addr_q,     addr_d;
   logic        mode_q,     mode_d;
   logic [2:0]  index_q,    index_d;
   logic [15:0] mem_addr_q, mem_addr_d;
   logic [3:0]  count_q,    count_d;
   logic        rf_wen_s;

   // Priority encoder: index of the lowest set bit (0 when the mask is empty).
   function automatic logic [2:0] lowest_set(input logic [7:0] m);
      logic [2:0] idx;
      idx = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (m[k]) begin
            idx = 3'(k);
         end
      end
      return idx;
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or posedge proc_rst) begin
      if (proc_rst) begin
         state_q    <= ST_IDLE;
         mask_q     <= 8'd0;
         addr_q     <= 16'd0;
         mode_q     <= 1'b0;
         index_q    <= 3'd0;
         mem_addr_q <= 16'd0;
         count_q    <= 4'd0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         addr_q     <= addr_d;
         mode_q     <= mode_d;
         index_q    <= index_d;
         mem_addr_q <= mem_addr_d;
         count_q    <= count_d;
      end
   end

   // Next-state logic and the ready-qualified write strobe.
   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      addr_d     = addr_q;
      mode_d     = mode_q;
      index_d    = index_q;
      mem_addr_d = mem_addr_q;
      count_d    = count_q;
      rf_wen_s   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mask_d  = reg_list;
               addr_d  = base_addr;
               mode_d  = is_store;
               count_d = 4'd0;
               state_d = ST_SCAN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (mask_q == 8'd0) begin
               state_d = ST_DONE;
            end else begin
               // mem_addr/rf_index are loaded here so they stay put between
               // accesses even though addr_q advances at the end of ACCESS.
               index_d    = lowest_set(mask_q);
               mem_addr_d = addr_q;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (mem_ready) begin
               rf_wen_s = ~mode_q;
               mask_d   = mask_q & ~(8'd1 << index_q);
               addr_d   = addr_q + 16'd1;   // wraps modulo 2^16
               count_d  = count_q + 4'd1;
               state_d  = ST_SCAN;
            end else begin
               state_d = ST_ACCESS;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Memory requests decode from state only, so they cannot glitch with mem_ready.
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_DONE);
   assign mem_read   = (state_q == ST_ACCESS) & ~mode_q;
   assign mem_write  = (state_q == ST_ACCESS) &  mode_q;
   assign rf_wen     = rf_wen_s;
   assign rf_index   = index_q;
   assign mem_addr   = mem_addr_q;
   assign xfer_count = count_q;

endmodule
